// File: rtl/sram8_word_adapter_pkg.sv
// Shared types and constants for the 32-bit to byte-wide SRAM adapter.
// Contents: FSM state encoding, lane count and lane index width.
package sram8_adapter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } sram8_state_e;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

endpackage

// File: rtl/sram8_word_adapter_if.sv
// Word-side req/gnt/rvalid bus between a core or interconnect and the adapter.
// Signals:
//   req, addr, we, be, wdata : driven by the requester (master)
//   gnt, rvalid, rdata       : driven by the adapter (slave)
interface sram8_word_adapter_if
  import sram8_adapter_pkg::*;
#(
  parameter int AW = 10
);

  logic                 req;
  logic                 gnt;
  logic [AW-1:0]        addr;
  logic                 we;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wdata;
  logic                 rvalid;
  logic [31:0]          rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/sram8_word_adapter_lane_sel.sv
// Lowest-set-bit encoder for the remaining byte-lane mask.
// Ports:
//   mask      in  : lanes still to be issued
//   lane      out : index of the lowest set bit (0 when mask is empty)
//   mask_next out : mask with that bit cleared
module sram8_lane_sel
  import sram8_adapter_pkg::*;
(
  input  logic [NUM_LANES-1:0] mask,
  output logic [LANE_W-1:0]    lane,
  output logic [NUM_LANES-1:0] mask_next
);

  always_comb begin
    lane      = 2'd0;
    mask_next = mask;
    if (mask[0]) begin
      lane         = 2'd0;
      mask_next[0] = 1'b0;
    end else if (mask[1]) begin
      lane         = 2'd1;
      mask_next[1] = 1'b0;
    end else if (mask[2]) begin
      lane         = 2'd2;
      mask_next[2] = 1'b0;
    end else if (mask[3]) begin
      lane         = 2'd3;
      mask_next[3] = 1'b0;
    end
  end

endmodule

// File: rtl/sram8_word_adapter.sv
// Bridges a 32-bit req/gnt/rvalid bus onto a byte-wide single-port SRAM
// wrapper with 1-cycle read latency. Each word access is split into one byte
// access per enabled lane (ascending), and read bytes are reassembled.
//
// state  | meaning
// IDLE   | granting; waiting for req
// ACCESS | issuing one enabled byte lane per cycle
// DRAIN  | SRAM idle; capturing the last read byte
// RESP   | one-cycle rvalid pulse with assembled rdata
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   bus            : word-side slave port (req/gnt/addr/we/be/wdata/rvalid/rdata)
//   sram_*_o       : byte macro controls, connect 1:1 to the wrapper
//   sram_rdata_i   : macro read byte, valid the cycle after an enabled read
//   ram_ctrl_i/_o  : macro timing control, passed straight through
module sram8_word_adapter
  import sram8_adapter_pkg::*;
#(
  parameter int AW         = 10,
  parameter int RAM_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram8_word_adapter_if.slave   bus,
  output logic                  sram_en_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [7:0]            sram_wdata_o,
  output logic                  sram_be_o,
  input  logic [7:0]            sram_rdata_i,
  input  logic [RAM_CTRL_W-1:0] ram_ctrl_i,
  output logic [RAM_CTRL_W-1:0] ram_ctrl_o
);

  sram8_state_e         state_q, state_d;
  logic [AW-3:0]        addr_q;
  logic                 we_q;
  logic [NUM_LANES-1:0] mask_q;
  logic [31:0]          wdata_q;
  logic [31:0]          acc_q;
  logic [LANE_W-1:0]    lane_q;
  logic                 cap_q;

  logic [LANE_W-1:0]    lane;
  logic [NUM_LANES-1:0] mask_next;
  logic                 accept;

  // Word-aligned bus: the byte offset bits carry no information.
  logic                 addr_lsb_unused;
  assign addr_lsb_unused = ^bus.addr[1:0];

  assign accept     = (state_q == IDLE) && bus.req;
  assign sram_be_o  = 1'b1;
  assign ram_ctrl_o = ram_ctrl_i;

  sram8_lane_sel u_lane_sel (
    .mask      (mask_q),
    .lane      (lane),
    .mask_next (mask_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus.gnt      = 1'b0;
    bus.rvalid   = 1'b0;
    bus.rdata    = 32'h0;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = 8'h00;
    case (state_q)
      IDLE: begin
        bus.gnt = 1'b1;
        if (bus.req) begin
          state_d = (bus.be == '0) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        sram_en_o    = 1'b1;
        sram_we_o    = we_q;
        sram_addr_o  = {addr_q, lane};
        sram_wdata_o = wdata_q[{lane, 3'b000} +: 8];
        if (mask_next == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = RESP;
      end
      RESP: begin
        bus.rvalid = 1'b1;
        bus.rdata  = acc_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read bytes arrive one cycle after issue, so the lane index and a
  // read-issued flag are carried one stage to steer the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= 32'h0;
      acc_q   <= 32'h0;
      lane_q  <= '0;
      cap_q   <= 1'b0;
    end else begin
      cap_q  <= (state_q == ACCESS) && !we_q;
      lane_q <= lane;
      if (accept) begin
        addr_q  <= bus.addr[AW-1:2];
        we_q    <= bus.we;
        mask_q  <= bus.be;
        wdata_q <= bus.wdata;
      end else if (state_q == ACCESS) begin
        mask_q  <= mask_next;
      end
      if (accept) begin
        acc_q <= 32'h0;
      end else if (cap_q) begin
        acc_q[{lane_q, 3'b000} +: 8] <= sram_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_sram8_word_adapter.sv
// Scoreboard bench for sram8_word_adapter with a behavioural byte SRAM.
module tb_sram8_word_adapter;

  localparam int AW = 10;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    string         name;
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sram_en, sram_we, sram_be;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_wdata;
  logic [7:0]    sram_rdata = 8'h00;
  logic [4:0]    ram_ctrl_i = 5'd0;
  logic [4:0]    ram_ctrl_o;

  logic [7:0]    mem [1024];

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  int rvalid_cnt = 0;
  int exp_rvalid = 0;

  resp_t resp_q[$];
  acc_t  sram_q[$];

  always #5 clk = ~clk;

  sram8_word_adapter_if #(.AW(AW)) bif ();

  sram8_word_adapter #(.AW(AW), .RAM_CTRL_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bif),
    .sram_en_o    (sram_en),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_be_o    (sram_be),
    .sram_rdata_i (sram_rdata),
    .ram_ctrl_i   (ram_ctrl_i),
    .ram_ctrl_o   (ram_ctrl_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Byte SRAM: 1-cycle read latency.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  always @(posedge clk) ram_ctrl_i = 5'($urandom_range(0, 31));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents rvalid or an SRAM access.
  always @(negedge clk) begin
    resp_t r;
    acc_t  a;
    if (rst_n) begin
      check("ram_ctrl_passthru", 32'(ram_ctrl_o), 32'(ram_ctrl_i));
      if (bif.rvalid) begin
        rvalid_cnt++;
        if (resp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_rvalid: got rvalid at cycle %0d expected none", cyc);
        end else begin
          r = resp_q.pop_front();
          check({r.name, "_rvalid_cycle"}, 32'(cyc), 32'(r.cyc));
          check({r.name, "_rdata"}, bif.rdata, r.rdata);
        end
      end
      if (sram_en) begin
        if (sram_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_sram_en: got access addr %h at cycle %0d expected none", sram_addr, cyc);
        end else begin
          a = sram_q.pop_front();
          check({a.name, "_sram_cycle"}, 32'(cyc), 32'(a.cyc));
          check({a.name, "_sram_we"}, 32'(sram_we), 32'(a.we));
          check({a.name, "_sram_addr"}, 32'(sram_addr), 32'(a.addr));
          if (a.we) check({a.name, "_sram_wdata"}, 32'(sram_wdata), 32'(a.wdata));
        end
      end else begin
        check("sram_we_outside_access", 32'(sram_we), 32'd0);
      end
    end
  end

  // Issue one word transaction; push the expected response and byte accesses.
  task automatic issue(input string name, input logic [AW-1:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input int lat,
                       input bit keep_req, output int t_acc);
    int guard = 0;
    int k = 0;
    logic [1:0] lb;
    @(negedge clk);
    bif.req = 1'b1; bif.addr = a; bif.we = w; bif.be = b; bif.wdata = d;
    while (!bif.gnt && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    t_acc = -1;
    if (!bif.gnt) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_accept_timeout: got gnt=0 expected gnt=1 within 50 cycles", name);
      bif.req = 1'b0;
    end else begin
      t_acc = cyc;
      resp_q.push_back('{name, exp_rdata, cyc + lat});
      exp_rvalid++;
      for (int l = 0; l < 4; l++) begin
        if (b[l]) begin
          k++;
          lb = 2'(l);
          sram_q.push_back('{name, cyc + k, w, {a[AW-1:2], lb}, d[8*l +: 8]});
        end
      end
      @(posedge clk);
      #1;
      // Scramble the bus while busy; it must not matter.
      bif.req = keep_req; bif.addr = ~a; bif.we = ~w; bif.be = ~b; bif.wdata = 32'hDEADBEEF;
    end
  endtask

  initial begin
    int t, ta, tb;
    int guard;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h080] = 8'h55; mem[10'h081] = 8'h66; mem[10'h082] = 8'h77; mem[10'h083] = 8'h88;
    bif.req = 1'b0; bif.addr = '0; bif.we = 1'b0; bif.be = 4'h0; bif.wdata = 32'h0;

    #2;
    check("rst_gnt", 32'(bif.gnt), 32'd1);
    check("rst_rvalid", 32'(bif.rvalid), 32'd0);
    check("rst_rdata", bif.rdata, 32'h0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_sram_wdata", 32'(sram_wdata), 32'd0);
    check("sram_be_tied", 32'(sram_be), 32'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    issue("t1_wr_full", 10'h040, 1'b1, 4'b1111, 32'hA1B2C3D4, 32'h0, 6, 1'b0, t);
    issue("t2_rd_full", 10'h040, 1'b0, 4'b1111, 32'h0, 32'hA1B2C3D4, 6, 1'b0, t);
    issue("t3_rd_0101", 10'h041, 1'b0, 4'b0101, 32'h0, 32'h00B200D4, 4, 1'b0, t);

    issue("t4_wr_be0", 10'h040, 1'b1, 4'b0000, 32'h12345678, 32'h0, 1, 1'b0, t);
    @(negedge clk);
    check("t4_gnt_low_t1", 32'(bif.gnt), 32'd0);
    @(negedge clk);
    check("t4_gnt_high_t2", 32'(bif.gnt), 32'd1);

    // Reset during the third byte: lanes 0,1 land, lanes 2,3 never issue.
    issue("t5_wr_rst", 10'h080, 1'b1, 4'b1111, 32'h11223344, 32'h0, 6, 1'b0, t);
    if (t >= 0) begin
      void'(resp_q.pop_back());
      exp_rvalid--;
      void'(sram_q.pop_back());
      void'(sram_q.pop_back());
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_en_drops", 32'(sram_en), 32'd0);
      check("t5_gnt_in_rst", 32'(bif.gnt), 32'd1);
      check("t5_rvalid_in_rst", 32'(bif.rvalid), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t5_gnt_after_rst", 32'(bif.gnt), 32'd1);
    end
    issue("t5_rd_back", 10'h080, 1'b0, 4'b1111, 32'h0, 32'h88773344, 6, 1'b0, t);

    issue("t6a_rd_0011", 10'h040, 1'b0, 4'b0011, 32'h0, 32'h0000C3D4, 4, 1'b1, ta);
    issue("t6b_rd_1000", 10'h040, 1'b0, 4'b1000, 32'h0, 32'hA1000000, 3, 1'b0, tb);
    check("t6_second_accept_gap", 32'(tb - ta), 32'd5);

    issue("t7_wr_1010", 10'h100, 1'b1, 4'b1010, 32'hCAFEF00D, 32'h0, 4, 1'b0, t);
    issue("t7_rd_back", 10'h102, 1'b0, 4'b1111, 32'h0, 32'hCA00F000, 6, 1'b0, t);

    guard = 0;
    while ((resp_q.size() != 0 || sram_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("pending_responses", 32'(resp_q.size()), 32'd0);
    check("pending_sram_accesses", 32'(sram_q.size()), 32'd0);
    check("rvalid_pulse_count", 32'(rvalid_cnt), 32'(exp_rvalid));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
